dance_ctrl: RTL



---
 rtl/dance_pkg.sv | 26 ++
 rtl/sw_debounce.sv | 51 +++++
 rtl/dance_ctrl.sv | 119 +++++++++++
 3 files changed

// File: rtl/dance_pkg.sv
// dance_pkg: definitions shared by dance_ctrl and the LED pattern stage.
//   state_e    - control FSM states (IDLE, CHANGE, RUN)
//   MODE_*     - one-hot pattern mode encodings
//   decode_req - fixed-priority switch-to-mode decode
package dance_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_CHANGE,
    ST_RUN
  } state_e;

  localparam logic [2:0] MODE_NONE   = 3'b000;
  localparam logic [2:0] MODE_RL     = 3'b001;
  localparam logic [2:0] MODE_LR     = 3'b010;
  localparam logic [2:0] MODE_BOUNCE = 3'b100;

  // SW0 beats SW1 beats SW2; no switch means idle.
  function automatic logic [2:0] decode_req(input logic [2:0] sw_clean);
    if (sw_clean[0])      return MODE_RL;
    else if (sw_clean[1]) return MODE_LR;
    else if (sw_clean[2]) return MODE_BOUNCE;
    else                  return MODE_NONE;
  endfunction

endpackage

// File: rtl/sw_debounce.sv
// sw_debounce: single-bit 2-flop synchroniser followed by a debouncer.
// The clean output flips only after the synchronised input has disagreed
// with it for DEBOUNCE_CYCLES consecutive cycles; any agreeing cycle
// restarts the count.
// Ports:
//   Clock   - system clock, rising edge
//   Resetn  - asynchronous active-low reset
//   raw_i   - raw (asynchronous) switch input
//   clean_o - debounced level
module sw_debounce #(
  parameter int unsigned DEBOUNCE_CYCLES = 500000
) (
  input  logic Clock,
  input  logic Resetn,
  input  logic raw_i,
  output logic clean_o
);

  localparam int unsigned DW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [DW-1:0] LAST = DW'(DEBOUNCE_CYCLES - 1);

  logic          sync1_q, sync2_q;
  logic          clean_q, clean_d;
  logic [DW-1:0] cnt_q, cnt_d;

  always_comb begin
    clean_d = clean_q;
    cnt_d   = '0;
    if (sync2_q != clean_q) begin
      if (cnt_q == LAST) clean_d = sync2_q;
      else               cnt_d   = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      clean_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= raw_i;
      sync2_q <= sync1_q;
      clean_q <= clean_d;
      cnt_q   <= cnt_d;
    end
  end

  assign clean_o = clean_q;

endmodule

// File: rtl/dance_ctrl.sv
// dance_ctrl: front-end control for the LED dance pattern generator.
// Debounces the four slide switches, resolves a one-hot pattern mode and
// generates the step tick that advances the LED position.
// Ports:
//   Clock       - system clock, rising edge
//   Resetn      - asynchronous active-low reset
//   SW[3:0]     - raw switches: [0] R->L, [1] L->R, [2] bounce, [3] fast
//   mode[2:0]   - registered one-hot mode (000 idle)
//   fast        - debounced SW[3], one register stage
//   step_tick   - one-cycle advance pulse
//   mode_change - one-cycle pulse in the cycle mode takes its new value
module dance_ctrl
  import dance_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 500000,
  parameter int unsigned TICK_SLOW       = 16777216,
  parameter int unsigned TICK_FAST       = 4194304
) (
  input  logic       Clock,
  input  logic       Resetn,
  input  logic [3:0] SW,
  output logic [2:0] mode,
  output logic       fast,
  output logic       step_tick,
  output logic       mode_change
);

  localparam int unsigned TICK_MAX = (TICK_SLOW > TICK_FAST) ? TICK_SLOW : TICK_FAST;
  localparam int unsigned CW       = (TICK_MAX > 1) ? $clog2(TICK_MAX) : 1;
  localparam logic [CW-1:0] SLOW_LAST = CW'(TICK_SLOW - 1);
  localparam logic [CW-1:0] FAST_LAST = CW'(TICK_FAST - 1);

  logic [3:0] clean;
  logic [2:0] req;

  for (genvar g = 0; g < 4; g++) begin : g_sw
    sw_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_db (
      .Clock  (Clock),
      .Resetn (Resetn),
      .raw_i  (SW[g]),
      .clean_o(clean[g])
    );
  end

  assign req = decode_req(clean[2:0]);

  state_e        state_q, state_d;
  logic [2:0]    mode_q, mode_d;
  logic          fast_q, fast_d;
  logic          tick_q, tick_d;
  logic          chg_q, chg_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [CW-1:0] last_q, last_d;

  // Wrap point for the current speed and for the speed taking effect next.
  assign last_q = fast_q ? FAST_LAST : SLOW_LAST;
  assign last_d = fast_d ? FAST_LAST : SLOW_LAST;

  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    chg_d   = 1'b0;
    cnt_d   = '0;
    fast_d  = clean[3];
    case (state_q)
      ST_IDLE: begin
        if (req != MODE_NONE) begin
          state_d = ST_CHANGE;
          mode_d  = req;
          chg_d   = 1'b1;
        end
      end
      ST_CHANGE: begin
        state_d = (mode_q != MODE_NONE) ? ST_RUN : ST_IDLE;
      end
      ST_RUN: begin
        if (req != mode_q) begin
          state_d = ST_CHANGE;
          mode_d  = req;
          chg_d   = 1'b1;
        end else begin
          cnt_d = (cnt_q >= last_q) ? '0 : cnt_q + 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    // The request is latched straight into mode on entry to CHANGE, so the
    // pulse and the new mode appear together. The tick is registered from
    // the next count so it is high in the cycle the count sits at its last
    // value; using the next speed makes a slow->fast change wrap at once.
    tick_d = (state_d == ST_RUN) && (cnt_d >= last_d);
  end

  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      state_q <= ST_IDLE;
      mode_q  <= MODE_NONE;
      fast_q  <= 1'b0;
      tick_q  <= 1'b0;
      chg_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      fast_q  <= fast_d;
      tick_q  <= tick_d;
      chg_q   <= chg_d;
      cnt_q   <= cnt_d;
    end
  end

  assign mode        = mode_q;
  assign fast        = fast_q;
  assign step_tick   = tick_q;
  assign mode_change = chg_q;

endmodule
